// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, legal oversampling ratios and default word width for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_t;
  localparam logic [5:0] PS8 = 6'd8;
  localparam logic [5:0] PS16 = 6'd16;
  localparam logic [5:0] PS32 = 6'd32;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic logic legal_ps(input logic [5:0] ps);
    return ps inside {PS8, PS16, PS32};
  endfunction
endpackage

// File: rtl/rx_sampler.sv
// rx_sampler: takes three samples around mid-bit and presents their 2-of-3 majority.
module rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic [5:0] edge_cnt,
  output logic       maj
);
  logic [5:0] half;
  logic [2:0] s;
  assign half = {1'b0, prescale[5:1]};
  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else if (edge_cnt == half - 6'd1) s[0] <= rx_in;
    else if (edge_cnt == half) s[1] <= rx_in;
    else if (edge_cnt == half + 6'd1) s[2] <= rx_in;
  end
  assign maj = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM driven by an external edge/bit counter.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_en,
  output logic [DATA_WIDTH-1:0] p_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic maj, bend, spt, to_par, pe_flag, se_flag;
  rx_sampler u_sampler (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .edge_cnt(edge_cnt), .maj(maj)
  );
  assign bend = edge_cnt == prescale - 6'd1;
  assign spt = edge_cnt == (prescale >> 1) + 6'd2;
  assign cnt_en = state inside {START, DATA, PARITY, STOP};
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (!rx_in && legal_ps(prescale)) ? START : IDLE;
      START: nxt = bend ? (maj ? IDLE : DATA) : START;
      DATA: nxt = (bend && bit_cnt == 4'(DATA_WIDTH)) ? (to_par ? PARITY : STOP) : DATA;
      PARITY: nxt = bend ? STOP : PARITY;
      STOP: nxt = bend ? CHECK : STOP;
      CHECK: nxt = rx_in ? IDLE : START;
      default: nxt = IDLE;
    endcase
  end
`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_typ_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      pe_flag <= 1'b0;
    end else begin
      if (nxt == START && state != START) begin
        par_en_q <= par_en;
        par_typ_q <= par_typ;
      end
      if (state == PARITY && spt) pe_flag <= (^shreg ^ par_typ_q) != maj;
      else if (state == CHECK) pe_flag <= 1'b0;
    end
  end
  assign to_par = par_en_q;
`else
  logic unused_cfg;
  assign unused_cfg = par_en ^ par_typ;
  assign pe_flag = 1'b0;
  assign to_par = 1'b0;
`endif
  // Pulses are registered at the CHECK edge so they line up with the new p_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      se_flag <= 1'b0;
      p_out <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else begin
      state <= nxt;
      data_valid <= state == CHECK && !pe_flag && !se_flag;
      par_err <= state == CHECK && pe_flag;
      stp_err <= state == CHECK && se_flag;
      if (state == DATA && spt) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
      if (state == STOP && spt) se_flag <= !maj;
      else if (state == CHECK) se_flag <= 1'b0;
      if (state == CHECK && !pe_flag && !se_flag) p_out <= shreg;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame vectors plus corner sequences for uart_rx_ctrl, with a model of the edge/bit counter.
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst, rx_in, par_en, par_typ, cnt_en, data_valid, par_err, stp_err;
  logic [5:0] prescale, edge_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] p_out;
  int n_vec = 0, n_bad = 0;
  int dv_cnt, pe_cnt, se_cnt, lo_cnt;
  logic [7:0] last_p, exp_p;
  typedef struct {
    int ps;
    bit pen, ptyp;
    logic [7:0] data;
    bit spar, pbit, sbit, flip;
    int edv, epe, ese;
  } vec_t;
  vec_t vecs[$];

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .cnt_en(cnt_en),
    .p_out(p_out), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (edge_cnt == prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt <= bit_cnt + 4'd1;
    end else edge_cnt <= edge_cnt + 6'd1;
  end

  task automatic tick();
    @(negedge clk);
    dv_cnt += int'(data_valid);
    pe_cnt += int'(par_err);
    se_cnt += int'(stp_err);
    lo_cnt += int'(!cnt_en);
    if (data_valid) last_p = p_out;
  endtask

  task automatic clear_counts();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; lo_cnt = 0;
  endtask

  task automatic drive_bit(input logic v, input int ps);
    rx_in = v;
    repeat (ps) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input vec_t v);
    prescale = 6'(v.ps);
    par_en = v.pen;
    par_typ = v.ptyp;
    drive_bit(1'b0, v.ps);
    if (v.flip) begin
      par_en = ~par_en;
      par_typ = ~par_typ;
    end
    for (int i = 0; i < 8; i++) drive_bit(v.data[i], v.ps);
    if (v.spar) drive_bit(v.pbit, v.ps);
    drive_bit(v.sbit, v.ps);
  endtask

  initial begin
    vecs.push_back('{8, 0, 0, 8'hA5, 0, 0, 1, 0, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{16, 1, 0, 8'h3C, 1, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{16, 1, 0, 8'h3C, 1, 1, 1, 0, 0, 1, 0});
    vecs.push_back('{16, 1, 1, 8'h07, 1, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{8, 1, 0, 8'hE1, 1, 1, 0, 0, 0, 1, 1});
`else
    vecs.push_back('{16, 1, 0, 8'h3C, 0, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{16, 1, 1, 8'h5A, 0, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{8, 1, 0, 8'hE1, 1, 0, 1, 0, 0, 0, 1});
`endif
    vecs.push_back('{32, 0, 0, 8'h81, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{32, 0, 0, 8'hC3, 0, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{8, 0, 0, 8'h96, 0, 0, 1, 1, 1, 0, 0});

    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    clear_counts();
    last_p = '0;
    exp_p = '0;
    repeat (3) tick();
    chk("reset cnt_en", int'(cnt_en), 0);
    chk("reset p_out", int'(p_out), 0);
    chk("reset pulses", int'({data_valid, par_err, stp_err}), 0);
    rst = 1'b0;
    repeat (4) tick();

    foreach (vecs[k]) begin
      clear_counts();
      send_frame(vecs[k]);
      rx_in = 1'b1;
      repeat (6) tick();
      if (vecs[k].edv != 0) exp_p = vecs[k].data;
      chk($sformatf("vec%0d data_valid", k), dv_cnt, vecs[k].edv);
      chk($sformatf("vec%0d par_err", k), pe_cnt, vecs[k].epe);
      chk($sformatf("vec%0d stp_err", k), se_cnt, vecs[k].ese);
      chk($sformatf("vec%0d p_out", k), int'(p_out), int'(exp_p));
      chk($sformatf("vec%0d idle", k), int'(cnt_en), 0);
      if (vecs[k].edv != 0) chk($sformatf("vec%0d p_at_valid", k), int'(last_p), int'(exp_p));
    end

    // start glitch: START is held for one full bit, then back to IDLE
    clear_counts();
    prescale = 6'd8;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    chk("glitch low cycles", lo_cnt, 15);
    chk("glitch pulses", dv_cnt + pe_cnt + se_cnt, 0);
    chk("glitch p_out", int'(p_out), int'(exp_p));

    // illegal prescale keeps IDLE
    clear_counts();
    prescale = 6'd12;
    drive_bit(1'b0, 20);
    chk("illegal ps cnt_en low", lo_cnt, 20);
    prescale = 6'd8;
    drive_bit(1'b1, 4);

    // back-to-back frames: only the CHECK cycle separates them
    clear_counts();
    send_frame('{8, 0, 0, 8'h01, 0, 0, 1, 0, 1, 0, 0});
    send_frame('{8, 0, 0, 8'hFF, 0, 0, 1, 0, 1, 0, 0});
    chk("b2b gap cycles", lo_cnt, 1);
    rx_in = 1'b1;
    repeat (6) tick();
    exp_p = 8'hFF;
    chk("b2b data_valid", dv_cnt, 2);
    chk("b2b p_out", int'(p_out), int'(exp_p));
    chk("b2b errors", pe_cnt + se_cnt, 0);

    // reset in the middle of DATA
    clear_counts();
    prescale = 6'd16;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    chk("pre-reset cnt_en", int'(cnt_en), 1);
    rst = 1'b1;
    rx_in = 1'b1;
    tick();
    chk("reset cnt_en", int'(cnt_en), 0);
    rst = 1'b0;
    repeat (40) tick();
    exp_p = '0;
    chk("reset aborted pulses", dv_cnt + pe_cnt + se_cnt, 0);
    chk("reset p_out cleared", int'(p_out), int'(exp_p));
    chk("reset stays idle", int'(cnt_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 Port: clk  input  1  single clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: rx_in  input  1  serial line, idle high.
REQ-005 Port: prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 Port: par_en  input  1  parity bit present.
REQ-007 Port: par_typ  input  1  parity type: 0 even, 1 odd.
REQ-008 Port: edge_cnt  input  6  edge count within the current bit, from the edge/bit counter.
REQ-009 Port: bit_cnt  input  4  bit index within the frame, from the edge/bit counter; 0 is the start bit.
REQ-010 Port: cnt_en  output  1  counter enable; counter clears while low.
REQ-011 Port: p_out  output  DATA_WIDTH  received data word.
REQ-012 Port: data_valid  output  1  one-cycle pulse; p_out holds a new good word.
REQ-013 Port: par_err  output  1  one-cycle parity-error pulse.
REQ-014 Port: stp_err  output  1  one-cycle stop-error pulse.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP and CHECK; cnt_en SHALL be high only in START, DATA, PARITY and STOP.
REQ-016 rx_in SHALL be sampled on edge_cnt == prescale/2-1, prescale/2 and prescale/2+1; the 2-of-3 majority SHALL be valid at edge_cnt == prescale/2+2 (the sample point).
REQ-017 A bit end SHALL be edge_cnt == prescale-1.
REQ-018 IDLE: rx_in == 0 SHALL move to START; par_en and par_typ SHALL be latched on this transition, and later changes SHALL have no effect on the current frame.
REQ-019 START: at bit end, majority 1 (glitch) SHALL return to IDLE with no error pulse; majority 0 SHALL move to DATA.
REQ-020 DATA: each sample point SHALL shift the majority into an internal register, LSB first.
REQ-021 DATA: at bit end with bit_cnt == DATA_WIDTH, the block SHALL move to PARITY if latched par_en is 1, otherwise to STOP.
REQ-022 PARITY: at the sample point, the error flag SHALL be set if the XOR of the data bits, XOR latched par_typ, differs from the sampled bit; at bit end the block SHALL move to STOP.
REQ-023 STOP: at the sample point, the stop-error flag SHALL be set if the majority is 0; at bit end the block SHALL move to CHECK.
REQ-024 CHECK lasts exactly one cycle: with no flag set, it SHALL load p_out and pulse data_valid; otherwise it SHALL pulse par_err and/or stp_err, leave p_out unchanged and not pulse data_valid.
REQ-025 CHECK SHALL then go to START if rx_in == 0 (back-to-back frame), else to IDLE; error flags SHALL clear on leaving CHECK.
REQ-026 p_out SHALL change only in CHECK with no error flag set.
REQ-027 A prescale value not in {8, 16, 32} seen in IDLE SHALL hold IDLE and ignore rx_in.

Reset
REQ-028 rst SHALL force IDLE and clear cnt_en, data_valid, par_err, stp_err, p_out, the shift register and the latched configuration on the next clk edge.
REQ-029 A reset during a frame SHALL abort it with no data_valid or error pulse.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, PARITY and par_err SHALL behave as in REQ-021/022.
REQ-031 Without UART_RX_PARITY_EN, par_en and par_typ SHALL be ignored, PARITY SHALL be unreachable (DATA always goes to STOP) and par_err SHALL be tied to 0; the ports SHALL remain.

Structure
REQ-032 The shared package uart_rx_pkg SHALL hold the state encoding, the legal prescale constants and the default DATA_WIDTH.
REQ-033 The 3-sample majority voter SHALL be a sub-module, rx_sampler; the edge/bit counter SHALL stay external.

Verification
REQ-034 prescale 8, par_en 0, frame 0x A5 -> data_valid pulses once in CHECK, p_out == 0xA5, no error pulses.
REQ-035 prescale 16, par_en 1, par_typ 0, data 0x3C with a correct parity bit (0) -> data_valid, p_out == 0x3C; the same frame with parity bit 1 -> par_err pulse, no data_valid, p_out unchanged.
REQ-036 prescale 32, stop bit driven 0 -> stp_err pulse, no data_valid, then IDLE.
REQ-037 rx_in low for 3 clocks only (start glitch), prescale 8 -> return to IDLE after START, no outputs asserted.
REQ-038 Two back-to-back frames, 0x01 then 0xFF -> two data_valid pulses, with CHECK going directly to START.
REQ-039 rst asserted during DATA -> IDLE next cycle, cnt_en 0, no pulses; without UART_RX_PARITY_EN, par_en 1 -> frame is treated as 10 bits and par_err stays 0.
